// File: rtl/qq_pkg.sv
// Shared types for the QuickQ scheduler front end.
package qq_pkg;

    typedef enum logic {
        OP_ENQ = 1'b0,
        OP_DEQ = 1'b1
    } op_e;

    typedef enum logic {
        READY    = 1'b0,
        COOLDOWN = 1'b1
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted requester.
// The pointer moves only when the grant is actually taken (grant_en_i).
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] eligible_i,
    input  logic            grant_en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   grant_idx_o,
    output logic            any_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW:0]   cand;

    always_comb begin
        any_o       = 1'b0;
        grant_idx_o = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!any_o && eligible_i[cand[IW-1:0]]) begin
                any_o       = 1'b1;
                grant_idx_o = cand[IW-1:0];
            end
        end
        grant_o = any_o ? (NREQ'(1) << grant_idx_o) : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_en_i && any_o) begin
            ptr_d = (grant_idx_o == IW'(NREQ-1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/qq_scheduler.sv
// Multi-client front end for the QuickQ priority queue: arbitration, issue
// spacing, occupancy tracking and routing of dequeued keys back to requesters.
//
//   state    | meaning
//   READY    | may grant one eligible requester this cycle
//   COOLDOWN | spacing window after a grant, gap counter running down
module qq_scheduler
    import qq_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int KW      = 16,
    parameter int DEPTH   = 64,
    parameter int GAP     = 2,
    parameter int DEQ_LAT = 3,
    localparam int IW     = $clog2(NREQ),
    localparam int CW     = $clog2(DEPTH+1),
    localparam int GW     = $clog2(GAP+1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_op,
    input  logic [NREQ-1:0][KW-1:0]  req_key,
    output logic [NREQ-1:0]          req_ready,
    output logic                     q_enq,
    output logic                     q_deq,
    output logic [KW-1:0]            q_key,
    input  logic [KW-1:0]            q_data_i,
    output logic                     rsp_valid,
    output logic [IW-1:0]            rsp_id,
    output logic [KW-1:0]            rsp_key,
    output logic [CW-1:0]            count,
    output logic                     full,
    output logic                     empty
);

    sched_state_e state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [CW-1:0] count_q;

    logic          q_enq_q, q_deq_q;
    logic [KW-1:0] q_key_q;
    logic [IW-1:0] cmd_id_q;

    logic [DEQ_LAT-1:0]         rsp_v_q;
    logic [DEQ_LAT-1:0][IW-1:0] rsp_id_q;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic            grant_en;
    logic            full_w, empty_w;
    op_e             sel_op;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // Eligibility looks at registered occupancy, so a grant this cycle is
    // reflected in the next cycle's decision.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] &&
                ((op_e'(req_op[i]) == OP_ENQ) ? !full_w : !empty_w);
        end
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk        (clk),
        .rst        (rst),
        .eligible_i (eligible),
        .grant_en_i (grant_en),
        .grant_o    (arb_grant),
        .grant_idx_o(arb_idx),
        .any_o      (arb_any)
    );

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        grant_en = 1'b0;
        case (state_q)
            READY: begin
                if (arb_any && !rst) begin
                    grant_en = 1'b1;
                    if (GAP > 1) begin
                        state_d = COOLDOWN;
                        gap_d   = GW'(GAP-1);
                    end
                end
            end
            COOLDOWN: begin
                gap_d = gap_q - 1'b1;
                if (gap_q == GW'(1)) begin
                    state_d = READY;
                end
            end
            default: state_d = READY;
        endcase
    end

    assign req_ready = grant_en ? arb_grant : '0;
    assign sel_op    = op_e'(req_op[arb_idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= READY;
            gap_q    <= '0;
            count_q  <= '0;
            q_enq_q  <= 1'b0;
            q_deq_q  <= 1'b0;
            q_key_q  <= '0;
            cmd_id_q <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            q_enq_q <= grant_en && (sel_op == OP_ENQ);
            q_deq_q <= grant_en && (sel_op == OP_DEQ);
            if (grant_en) begin
                cmd_id_q <= arb_idx;
                if (sel_op == OP_ENQ) begin
                    q_key_q <= req_key[arb_idx];
                    count_q <= count_q + 1'b1;
                end else begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

    // Response tracker: one stage per cycle of queue read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_v_q  <= '0;
            rsp_id_q <= '0;
        end else begin
            rsp_v_q[0]  <= q_deq_q;
            rsp_id_q[0] <= cmd_id_q;
            for (int s = 1; s < DEQ_LAT; s++) begin
                rsp_v_q[s]  <= rsp_v_q[s-1];
                rsp_id_q[s] <= rsp_id_q[s-1];
            end
        end
    end

    assign q_enq     = q_enq_q;
    assign q_deq     = q_deq_q;
    assign q_key     = q_key_q;
    assign rsp_valid = rsp_v_q[DEQ_LAT-1];
    assign rsp_id    = rsp_v_q[DEQ_LAT-1] ? rsp_id_q[DEQ_LAT-1] : '0;
    assign rsp_key   = q_data_i;
    assign count     = count_q;
    assign full      = full_w;
    assign empty     = empty_w;

endmodule

// File: tb/tb_qq_scheduler.sv
// Randomized scoreboard bench for qq_scheduler against a cycle-level
// behavioural model of grants, occupancy, commands and responses.
module tb_qq_scheduler;

    localparam int NREQ    = 4;
    localparam int KW      = 16;
    localparam int DEPTH   = 4;
    localparam int GAP     = 2;
    localparam int DEQ_LAT = 3;
    localparam int IW      = $clog2(NREQ);
    localparam int CW      = $clog2(DEPTH+1);

    typedef struct {
        int            cyc;
        bit            is_deq;
        logic [KW-1:0] key;
    } cmd_t;

    typedef struct {
        int            cyc;
        int            id;
        logic [KW-1:0] key;
    } rsp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NREQ-1:0]         rv  = '0;
    logic [NREQ-1:0]         rop = '0;
    logic [NREQ-1:0][KW-1:0] rkey = '0;
    logic [KW-1:0]           q_data_i;
    logic [NREQ-1:0]         req_ready;
    logic                    q_enq, q_deq;
    logic [KW-1:0]           q_key;
    logic                    rsp_valid;
    logic [IW-1:0]           rsp_id;
    logic [KW-1:0]           rsp_key;
    logic [CW-1:0]           count;
    logic                    full, empty;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  enq_pct = 50;
    bit  rand_en = 1'b0;
    logic [NREQ-1:0] granted_s = '0;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    cmd_t ce;
    rsp_t re;
    int   m_count = 0, m_ptr = 0, m_next_ok = 0, gi = 0, jj = 0;
    logic [KW-1:0]   m_key_last = '0;
    logic [NREQ-1:0] elig, exp_g;

    qq_scheduler #(
        .NREQ(NREQ), .KW(KW), .DEPTH(DEPTH), .GAP(GAP), .DEQ_LAT(DEQ_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(rv), .req_op(rop), .req_key(rkey), .req_ready(req_ready),
        .q_enq(q_enq), .q_deq(q_deq), .q_key(q_key), .q_data_i(q_data_i),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_key(rsp_key),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [KW-1:0] data_fn(input int c);
        logic [31:0] t;
        t = 32'(c) * 32'd40503 + 32'd7;
        return t[KW-1:0] ^ 16'h5a5a;
    endfunction

    assign q_data_i = data_fn(cyc);

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endfunction

    // Monitor, scoreboard and reference model, all evaluated mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", 64'(req_ready), 64'(0));
            chk("rst_q_enq", 64'(q_enq), 64'(0));
            chk("rst_q_deq", 64'(q_deq), 64'(0));
            chk("rst_q_key", 64'(q_key), 64'(0));
            chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("rst_rsp_id", 64'(rsp_id), 64'(0));
            chk("rst_count", 64'(count), 64'(0));
            chk("rst_full", 64'(full), 64'(0));
            chk("rst_empty", 64'(empty), 64'(1));
            cmd_q.delete();
            rsp_q.delete();
            m_count = 0; m_ptr = 0; m_next_ok = 0; m_key_last = '0;
            granted_s = '0;
        end else begin
            if (q_enq || q_deq) begin
                if (cmd_q.size() == 0) begin
                    chk("cmd_unexpected", 64'({q_enq, q_deq}), 64'(0));
                end else begin
                    ce = cmd_q.pop_front();
                    chk("cmd_cycle", 64'(cyc), 64'(ce.cyc));
                    chk("cmd_op", 64'({q_enq, q_deq}), ce.is_deq ? 64'(1) : 64'(2));
                    if (!ce.is_deq) begin
                        chk("q_key", 64'(q_key), 64'(ce.key));
                        m_key_last = ce.key;
                    end else begin
                        chk("q_key_hold", 64'(q_key), 64'(m_key_last));
                    end
                end
            end else begin
                chk("q_key_hold", 64'(q_key), 64'(m_key_last));
            end
            while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
                chk("cmd_missing", 64'(cyc), 64'(cmd_q[0].cyc));
                void'(cmd_q.pop_front());
            end

            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
                end else begin
                    re = rsp_q.pop_front();
                    chk("rsp_cycle", 64'(cyc), 64'(re.cyc));
                    chk("rsp_id", 64'(rsp_id), 64'(re.id));
                    chk("rsp_key", 64'(rsp_key), 64'(re.key));
                end
            end
            while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
                chk("rsp_missing", 64'(cyc), 64'(rsp_q[0].cyc));
                void'(rsp_q.pop_front());
            end

            chk("count", 64'(count), 64'(m_count));
            chk("full", 64'(full), 64'(m_count == DEPTH));
            chk("empty", 64'(empty), 64'(m_count == 0));

            elig = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (rv[i]) elig[i] = (rop[i] == 1'b0) ? (m_count < DEPTH) : (m_count > 0);
            end
            gi = -1;
            exp_g = '0;
            if (cyc >= m_next_ok) begin
                for (int k = 0; k < NREQ; k++) begin
                    jj = (m_ptr + k) % NREQ;
                    if (gi < 0 && elig[jj]) gi = jj;
                end
            end
            if (gi >= 0) exp_g[gi] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_g));
            if (gi >= 0) begin
                cmd_q.push_back('{cyc + 1, rop[gi], rkey[gi]});
                if (rop[gi]) begin
                    rsp_q.push_back('{cyc + 1 + DEQ_LAT, gi, data_fn(cyc + 1 + DEQ_LAT)});
                    m_count--;
                end else begin
                    m_count++;
                end
                m_ptr = (gi + 1) % NREQ;
                m_next_ok = cyc + GAP;
            end
            granted_s = req_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (granted_s[i]) rv[i] = 1'b0;
            if (rand_en) begin
                if (!rv[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        rv[i]   = 1'b1;
                        rop[i]  = ($urandom_range(0, 99) < enq_pct) ? 1'b0 : 1'b1;
                        rkey[i] = KW'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    rv[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            rv  = NREQ'($urandom);
            rop = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) rkey[i] = KW'($urandom);
            step();
        end
        rv  = '0;
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int i, input int maxc);
        int k;
        k = 0;
        while (rv[i] && k < maxc) begin
            step();
            k++;
        end
        chk("grant_timeout", 64'(rv[i]), 64'(0));
        rv[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        apply_reset();

        // single enqueue from requester 2
        rv[2] = 1'b1; rop[2] = 1'b0; rkey[2] = 16'h1234;
        wait_grant(2, 10);
        repeat (3) step();

        // all four enqueue continuously until full, then enq/deq contention
        apply_reset();
        for (int n2 = 0; n2 < 12; n2++) begin
            rv = '1; rop = '0;
            for (int i = 0; i < NREQ; i++) if (granted_s[i] == 1'b0) rkey[i] = KW'($urandom);
            step();
        end
        rv = '0;
        step();
        rv[0] = 1'b1; rop[0] = 1'b0;
        rv[3] = 1'b1; rop[3] = 1'b1;
        wait_grant(3, 10);
        rv = '0;
        repeat (8) step();

        // dequeue while empty stalls until an enqueue lands
        apply_reset();
        rv[1] = 1'b1; rop[1] = 1'b1;
        repeat (6) step();
        rv[0] = 1'b1; rop[0] = 1'b0; rkey[0] = KW'($urandom);
        wait_grant(1, 20);
        repeat (8) step();

        // reset one cycle after a dequeue is issued drops its response
        apply_reset();
        rv[0] = 1'b1; rop[0] = 1'b0; rkey[0] = 16'hbeef;
        wait_grant(0, 10);
        rv[2] = 1'b1; rop[2] = 1'b1;
        wait_grant(2, 10);
        step();
        rv  = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n = n + int'(rsp_valid);
            #1;
        end
        chk("rst_no_rsp", 64'(n), 64'(0));
        chk("rst_count_after", 64'(count), 64'(0));

        // randomized traffic with shifting enq/deq mix
        rand_en = 1'b1;
        enq_pct = 75; repeat (400) step();
        enq_pct = 25; repeat (400) step();
        apply_reset();
        enq_pct = 50; repeat (400) step();
        rand_en = 1'b0;
        rv = '0;
        repeat (15) step();
        chk("cmd_q_drained", 64'(cmd_q.size()), 64'(0));
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qq_scheduler.md
# qq_scheduler

Multi-client front end for the QuickQ priority-queue datapath. Arbitrates enqueue/dequeue requests from NREQ requesters round-robin, enforces queue full/empty and a minimum issue spacing, and drives the queue's single enq/deq/key command port. Tracks in-flight dequeues and routes each returned key back to the requester that asked for it.

## Interface
Parameters:
- NREQ, 4, number of requesters (≥2)
- KW, 16, key width in bits
- DEPTH, 64, queue capacity in entries
- GAP, 2, minimum cycles between issued commands (≥1; 1 = back-to-back)
- DEQ_LAT, 3, cycles from q_deq asserted to q_data_i valid (≥1)

Ports (clk and rst: one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  NREQ  request pending, per requester
- req_op  in  NREQ  per requester: 0 = enqueue, 1 = dequeue
- req_key  in  NREQ×KW  enqueue key, per requester (packed [NREQ-1:0][KW-1:0])
- req_ready  out  NREQ  one-hot grant; handshake completes when valid&ready
- q_enq  out  1  enqueue command pulse to queue
- q_deq  out  1  dequeue command pulse to queue
- q_key  out  KW  key accompanying q_enq
- q_data_i  in  KW  dequeued key from queue, valid DEQ_LAT cycles after q_deq
- rsp_valid  out  1  dequeue response valid (no backpressure)
- rsp_id  out  $clog2(NREQ)  requester index owning the response
- rsp_key  out  KW  dequeued key
- count  out  $clog2(DEPTH+1)  current queue occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Reset: req_ready=0, q_enq=0, q_deq=0, q_key=0, rsp_valid=0, rsp_id=0, count=0, full=0, empty=1, RR pointer=0, state READY, response pipeline cleared.
- Eligibility: requester i eligible iff req_valid[i] && (req_op[i]==ENQ ? !full : !empty).
- FSM: READY: if any eligible, grant one (req_ready one-hot, combinational from valid), go to COOLDOWN with gap counter = GAP-1; if GAP==1 stay READY. COOLDOWN: req_ready=0; decrement counter; return to READY when it reaches 0.
- Round-robin: search starts at last granted index +1, wraps at NREQ; pointer updates only on a grant.
- Requester holds valid, op, key stable until ready; dropping valid before grant is permitted.
- Count: +1 on issued enq, −1 on issued deq; at most one command per cycle, so no simultaneous inc/dec. Never exceeds DEPTH or goes below 0.
- Full: enq requesters stall; deq requesters still served. Empty: deq requesters stall; enq served.
- Response tracking: DEQ_LAT-stage shift register of {valid, id}, entered when q_deq issues.

## Timing
- Grant at cycle T (req_ready[i]=1). q_enq or q_deq =1 for exactly cycle T+1 (registered), q_key valid at T+1, else q_key holds last value.
- count/full/empty reflect the command from T+1.
- Next grant no earlier than T+GAP.
- Dequeue granted at T: rsp_valid=1, rsp_id=i for exactly cycle T+1+DEQ_LAT; rsp_key = q_data_i combinationally in that cycle.
- Eligibility at T uses count registered at T; a deq granted at T to the last entry blocks further deqs from T+1.
- Reset mid-operation: in-flight responses dropped (no rsp_valid after rst), command pulses cleared immediately, count=0.

## Structure
- qq_pkg: op_e enum (OP_ENQ=0, OP_DEQ=1), sched_state_e (READY, COOLDOWN).
- Sub-module rr_arbiter: NREQ-wide eligible vector in, one-hot grant and grant index out, internal rotating pointer advanced on grant_en.
- Top holds FSM, gap counter, occupancy counter, command registers, response shift register.

## Test plan
- Reset: rst high 3 cycles with random inputs -> all outputs at reset values, count=0, empty=1, full=0.
- Single enq, req 2 key 0x1234 at T -> req_ready=4'b0100 at T; q_enq=1, q_key=0x1234 at T+1; count=1 at T+1; no grant at T+1 (GAP=2).
- All four requesters enq continuously from reset -> grants 0,1,2,3,0 at T, T+2, T+4, T+6, T+8.
- Req 1 deq only while empty -> never ready; req 0 enq at T, req 1 granted at T+2, q_deq at T+3, rsp_valid=1, rsp_id=1, rsp_key=q_data_i at T+6 (DEQ_LAT=3).
- DEPTH=4: fill 4 -> full=1; req 0 enq and req 3 deq both valid -> only req 3 granted; count=3, full=0 after.
- Deq issued, rst pulsed at q_deq+1 -> no rsp_valid in following 10 cycles; count=0.
